// File: rtl/slew_pdm_gen.sv
// Slew-limited pulse-density generator: the density register ramps toward full
// or zero one step per prescaler tick and drives a first-order accumulator PDM.
module slew_pdm_gen #(
  parameter  int RATIO    = 256,
  parameter  int STEP_DIV = 1,
  localparam int W        = $clog2(RATIO)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         slow_in,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         pdm,
  output logic [W-1:0] dens_r,
  output logic         busy
);

  localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(STEP_DIV - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);
  localparam logic [W-1:0]  FULL     = '1;
  localparam logic [W-1:0]  ZERO     = '0;
  localparam logic [W-1:0]  ONE      = W'(1);

  logic [PW-1:0] pre_q, pre_d;
  logic [W-1:0]  dens_q, dens_d;
  logic [W-1:0]  acc_q, acc_d;
  logic          pdm_q, pdm_d;
  logic [W:0]    sum;
  logic          tick;

  assign tick = (pre_q == PRE_LAST);
  assign sum  = {1'b0, acc_q} + {1'b0, dens_q};

  always_comb begin
    pre_d  = pre_q;
    dens_d = dens_q;
    acc_d  = sum[W-1:0];
    pdm_d  = sum[W];
    if (dens_q == FULL) begin
      pdm_d = 1'b1;
    end else if (dens_q == ZERO) begin
      pdm_d = 1'b0;
    end

    // A load restarts the step phase and the modulator from a clean state.
    if (load) begin
      dens_d = load_val;
      pre_d  = '0;
      acc_d  = '0;
    end else begin
      pre_d = tick ? '0 : pre_q + PRE_ONE;
      if (tick) begin
        if (slow_in && dens_q != FULL) begin
          dens_d = dens_q + ONE;
        end else if (!slow_in && dens_q != ZERO) begin
          dens_d = dens_q - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q  <= '0;
      dens_q <= '0;
      acc_q  <= '0;
      pdm_q  <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      dens_q <= dens_d;
      acc_q  <= acc_d;
      pdm_q  <= pdm_d;
    end
  end

  assign pdm    = pdm_q;
  assign dens_r = dens_q;
  assign busy   = slow_in ? (dens_q != FULL) : (dens_q != ZERO);

endmodule

// File: tb/tb_slew_pdm_gen.sv
// Directed bench for slew_pdm_gen: three RATIO=16 instances with STEP_DIV 1, 4 and 1000.
module tb_slew_pdm_gen;

  logic clk = 1'b0;
  logic rst;

  logic       slow_in, load;
  logic [3:0] load_val;
  logic       pdm;
  logic [3:0] dens_r;
  logic       busy;

  logic       s_slow, s_load;
  logic [3:0] s_load_val;
  logic       s_pdm;
  logic [3:0] s_dens;
  logic       s_busy;

  logic       h_slow, h_load;
  logic [3:0] h_load_val;
  logic       h_pdm;
  logic [3:0] h_dens;
  logic       h_busy;

  int checks = 0;
  int errors = 0;
  logic samp [1:32];

  always #5 clk = ~clk;

  slew_pdm_gen #(.RATIO(16), .STEP_DIV(1)) dut (
    .clk(clk), .rst(rst), .slow_in(slow_in), .load(load), .load_val(load_val),
    .pdm(pdm), .dens_r(dens_r), .busy(busy)
  );

  slew_pdm_gen #(.RATIO(16), .STEP_DIV(4)) dut_s (
    .clk(clk), .rst(rst), .slow_in(s_slow), .load(s_load), .load_val(s_load_val),
    .pdm(s_pdm), .dens_r(s_dens), .busy(s_busy)
  );

  slew_pdm_gen #(.RATIO(16), .STEP_DIV(1000)) dut_h (
    .clk(clk), .rst(rst), .slow_in(h_slow), .load(h_load), .load_val(h_load_val),
    .pdm(h_pdm), .dens_r(h_dens), .busy(h_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int count_ones(input int first);
    int n = 0;
    for (int k = first; k < first + 16; k++) n += int'(samp[k]);
    return n;
  endfunction

  initial begin
    rst = 1'b1;
    slow_in = 1'b1; load = 1'b0; load_val = '0;
    s_slow = 1'b1; s_load = 1'b0; s_load_val = '0;
    h_slow = 1'b1; h_load = 1'b0; h_load_val = '0;
    step();
    step();
    chk("rst_dens", 32'(dens_r), 0);
    chk("rst_pdm", 32'(pdm), 0);
    chk("rst_busy_up", 32'(busy), 1);
    slow_in = 1'b0;
    #1;
    chk("rst_busy_down", 32'(busy), 0);
    slow_in = 1'b1;
    rst = 1'b0;

    // Ramp up to full scale; the STEP_DIV=4 instance ramps alongside.
    for (int i = 1; i <= 15; i++) begin
      step();
      $display("ramp_up edge %0d dens %0d busy %0d s_dens %0d", i, dens_r, busy, s_dens);
      chk("ramp_up_dens", 32'(dens_r), 32'(i));
      chk("ramp_up_busy", 32'(busy), (i == 15) ? 32'd0 : 32'd1);
      if (i == 3)  chk("div4_edge3", 32'(s_dens), 0);
      if (i == 4)  chk("div4_edge4", 32'(s_dens), 1);
      if (i == 7)  chk("div4_edge7", 32'(s_dens), 1);
      if (i == 8)  chk("div4_edge8", 32'(s_dens), 2);
      if (i == 12) chk("div4_edge12", 32'(s_dens), 3);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      $display("hold_full dens %0d pdm %0d", dens_r, pdm);
      chk("full_hold_dens", 32'(dens_r), 15);
      chk("full_pdm", 32'(pdm), 1);
    end

    // Load 10 while dropping slow_in, then ramp down to zero without wrapping.
    load = 1'b1; load_val = 4'd10; slow_in = 1'b0;
    step();
    load = 1'b0;
    chk("load10_dens", 32'(dens_r), 10);
    for (int j = 1; j <= 13; j++) begin
      step();
      $display("ramp_down step %0d dens %0d busy %0d pdm %0d", j, dens_r, busy, pdm);
      chk("ramp_down_dens", 32'(dens_r), (j <= 10) ? 32'(10 - j) : 32'd0);
      chk("ramp_down_busy", 32'(busy), (j < 10) ? 32'd1 : 32'd0);
      if (j >= 11) chk("zero_pdm", 32'(pdm), 0);
    end

    // Held density 8: pdm alternates starting with 0 after the load edge.
    h_load = 1'b1; h_load_val = 4'd8;
    step();
    h_load = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      step();
      samp[k] = h_pdm;
    end
    $display("dens8 pdm first %0d %0d ones %0d", samp[1], samp[2], count_ones(1));
    chk("d8_first", 32'(samp[1]), 0);
    chk("d8_second", 32'(samp[2]), 1);
    chk("d8_win1", 32'(count_ones(1)), 8);
    chk("d8_win9", 32'(count_ones(9)), 8);
    chk("d8_dens", 32'(h_dens), 8);

    // Held density 3: carries land on edges 6, 11, 16, 22, 27, 32.
    h_load = 1'b1; h_load_val = 4'd3;
    step();
    h_load = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      step();
      samp[k] = h_pdm;
    end
    $display("dens3 pdm edge5 %0d edge6 %0d ones %0d", samp[5], samp[6], count_ones(1));
    chk("d3_edge5", 32'(samp[5]), 0);
    chk("d3_edge6", 32'(samp[6]), 1);
    chk("d3_win1", 32'(count_ones(1)), 3);
    chk("d3_win2", 32'(count_ones(2)), 3);
    chk("d3_win17", 32'(count_ones(17)), 3);

    // Asynchronous reset in the middle of a ramp at density 7.
    rst = 1'b1;
    step();
    rst = 1'b0; slow_in = 1'b1;
    for (int i = 0; i < 7; i++) step();
    chk("pre_async_dens", 32'(dens_r), 7);
    #3 rst = 1'b1;
    #1;
    $display("async_rst dens %0d pdm %0d", dens_r, pdm);
    chk("async_dens", 32'(dens_r), 0);
    chk("async_pdm", 32'(pdm), 0);
    step();
    rst = 1'b0; s_slow = 1'b1;
    step();
    step();
    step();
    chk("div4_pre_load", 32'(s_dens), 0);

    // Load coinciding with a tick (edge 4) and a slow_in reversal: load wins.
    s_load = 1'b1; s_load_val = 4'd5; s_slow = 1'b0;
    load = 1'b1; load_val = 4'd5;
    step();
    s_load = 1'b0; load = 1'b0;
    $display("load_on_tick dens %0d s_dens %0d", dens_r, s_dens);
    chk("tick_load_dens", 32'(dens_r), 5);
    chk("tick_load_sdens", 32'(s_dens), 5);
    step();
    step();
    step();
    chk("resume_hold", 32'(s_dens), 5);
    step();
    $display("resume s_dens %0d", s_dens);
    chk("resume_down", 32'(s_dens), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slew_pdm_gen.md
SLEW_PDM_GEN -- requirements
Module: slew_pdm_gen

Interface
REQ-001 Parameter RATIO, default 256: full-scale density; W = clog2(RATIO); RATIO SHALL be a power of two, at least 8.
REQ-002 Parameter STEP_DIV, default 1: clk cycles per density step; SHALL be at least 1.
REQ-003 Port clk, input, 1: single clock; all state SHALL change on its rising edge only.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port slow_in, input, 1: target level; 1 ramps density toward full, 0 ramps it toward zero.
REQ-006 Port load, input, 1: single-cycle strobe that forces density to load_val.
REQ-007 Port load_val, input, W: density value applied on load.
REQ-008 Port pdm, output, 1: registered pulse-density bitstream.
REQ-009 Port dens_r, output, W: current density register.
REQ-010 Port busy, output, 1: high while density has not reached the endpoint selected by slow_in.

Function
REQ-011 Prescaler pre SHALL count 0..STEP_DIV-1 and wrap; tick SHALL be high in the cycle where pre == STEP_DIV-1.
REQ-012 On tick with slow_in=1 and dens_r != all-ones, dens_r SHALL increment by 1; at all-ones it SHALL hold (no wrap).
REQ-013 On tick with slow_in=0 and dens_r != 0, dens_r SHALL decrement by 1; at 0 it SHALL hold (no wrap).
REQ-014 No tick: dens_r SHALL hold.
REQ-015 load=1 SHALL take priority over tick: dens_r <= load_val, pre <= 0, acc <= 0, in the same cycle.
REQ-016 Accumulator acc SHALL be W bits; each cycle the sum {1'b0,acc}+{1'b0,dens_r} (W+1 bits) is formed; acc <= low W bits, carry = bit W.
REQ-017 pdm SHALL be registered: pdm <= 1 if dens_r is all-ones, 0 if dens_r is 0, else carry; the pdm value therefore reflects dens_r and acc from the previous cycle (one-cycle latency).
REQ-018 Over any RATIO consecutive cycles with constant dens_r D, where D is neither 0 nor all-ones, pdm SHALL be high exactly D times.
REQ-019 busy SHALL be combinational: busy = slow_in ? (dens_r != all-ones) : (dens_r != 0).
REQ-020 A slow_in change mid-ramp SHALL reverse the direction at the next tick without resetting pre or acc.
REQ-021 If load and a slow_in change occur in the same cycle, load_val SHALL win; ramping SHALL resume from load_val on later ticks.

Reset
REQ-022 While rst=1: dens_r=0, acc=0, pre=0, pdm=0; busy then follows REQ-019, so it is 1 if slow_in=1 and 0 if slow_in=0.
REQ-023 Reset asserted mid-ramp SHALL immediately clear all state; there SHALL be no ramp-down.
REQ-024 After rst falls, the first tick SHALL occur STEP_DIV rising edges later.

Verification (RATIO=16, STEP_DIV=1 unless noted)
REQ-025 Reset, then hold slow_in=1 -> dens_r = 1,2,...,15 on successive edges; busy=0 from the cycle where dens_r=15; dens_r stays at 15; pdm is constant 1 one cycle later.
REQ-026 load=1 with load_val=8 and slow_in toggling so density holds at 8 (or STEP_DIV=1000) -> pdm alternates 1,0 and shows exactly 8 ones per 16 cycles.
REQ-027 load_val=3 with density held -> exactly 3 pdm ones in every 16-cycle window after the first cycle.
REQ-028 Ramp up to 10, then drop slow_in -> dens_r = 9,8,...,0 and stops at 0 (no wrap to 15); pdm is constant 0 afterward; busy=0.
REQ-029 STEP_DIV=4, slow_in=1 after reset -> dens_r increments on the 4th, 8th and 12th edges; it is unchanged at the 3rd edge.
REQ-030 Assert rst asynchronously mid-ramp at dens_r=7 -> dens_r=0 and pdm=0 before the next clk edge; assert load with load_val=5 in the same cycle as a tick -> dens_r=5, not 5±1.
